// File: rtl/boot_pkg.sv
// Shared types and default constants for the boot loader slice.
package boot_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefRomAw = 4;
  localparam int unsigned DefRamAw = 8;

  localparam logic [15:0] DefExpCksum = 16'h9E0E;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StDone,
    StErr
  } boot_state_e;

endpackage

// File: rtl/boot_cksum.sv
// Additive modulo-2^DATA_W checksum of captured boot words, with match against the expected sum.
module boot_cksum
  import boot_pkg::*;
#(
  parameter int unsigned          DATA_W    = DefDataW,
  parameter logic [DATA_W-1:0]    EXP_CKSUM = DATA_W'(DefExpCksum)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum,
  output logic              match
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum   = sum_q;
  assign match = (sum_q == EXP_CKSUM);

endmodule

// File: rtl/boot_loader.sv
// Copies WORDS boot-ROM words into program RAM, holding the CPU in reset until done.
// Optional checksum verification is enabled with the BOOT_CKSUM_EN macro.
module boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned       ROM_AW     = DefRomAw,
  parameter int unsigned       DATA_W     = DefDataW,
  parameter int unsigned       RAM_AW     = DefRamAw,
  parameter int unsigned       SRC_BASE   = 0,
  parameter int unsigned       DST_BASE   = 0,
  parameter int unsigned       WORDS      = 7,
  parameter bit                AUTO_START = 1'b1,
  parameter logic [DATA_W-1:0] EXP_CKSUM  = DATA_W'(DefExpCksum)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rom_cs,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_din,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef BOOT_CKSUM_EN
  output logic [DATA_W-1:0] cksum,
`endif
  output logic              cpu_rst_n
);

  // WORDS <= 2^ROM_AW, so the last index always fits in ROM_AW bits.
  localparam int unsigned CntW = ROM_AW;

  boot_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic              first_q;
  logic              accept;
  logic              last;
  logic              rd_en;
  boot_state_e       fin_state;

  assign accept = (state_q inside {StIdle, StDone, StErr}) &&
                  (start || (AUTO_START && first_q));
  assign last   = (cnt_q == CntW'(WORDS - 1));
  assign rd_en  = (state_q == StRd);

`ifdef BOOT_CKSUM_EN
  logic cksum_ok;

  boot_cksum #(
    .DATA_W    (DATA_W),
    .EXP_CKSUM (EXP_CKSUM)
  ) u_cksum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (rd_en),
    .din   (rom_dout),
    .sum   (cksum),
    .match (cksum_ok)
  );

  assign fin_state = cksum_ok ? StDone : StErr;
`else
  logic unused_exp_cksum;

  assign unused_exp_cksum = ^EXP_CKSUM;
  assign fin_state        = StDone;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= 1'b0;
      if (rd_en) begin
        data_q <= rom_dout;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (accept) begin
          state_d = StRd;
          cnt_d   = '0;
        end
      end
      StRd: state_d = StWr;
      StWr: begin
        if (last) begin
          state_d = fin_state;
        end else begin
          state_d = StRd;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rom_we  = 1'b0;
  assign rom_din = '0;

  // Pure state decodes: rom_dout reaches outputs only through data_q.
  always_comb begin
    rom_cs    = 1'b0;
    rom_addr  = '0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b0;
    unique case (state_q)
      StRd: begin
        rom_cs   = 1'b1;
        rom_addr = ROM_AW'(SRC_BASE + 32'(cnt_q));
        busy     = 1'b1;
      end
      StWr: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = RAM_AW'(DST_BASE + 32'(cnt_q));
        ram_wdata = data_q;
        busy      = 1'b1;
      end
      StDone: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      StErr: begin
`ifdef BOOT_CKSUM_EN
        err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule
